// File: rtl/c1541_gcr_decoder.sv
// C1541 GCR read-path decoder: sync detection, 5-to-4 GCR decode, header and
// data block parsing with checksums, and sector-buffer write port.
module c1541_gcr_decoder (
  input  logic       clk32,
  input  logic       reset_n,
  input  logic       mtr,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic       sync_n,
  output logic [7:0] dout,
  output logic       byte_n,
  output logic       hdr_valid,
  output logic [5:0] hdr_track,
  output logic [4:0] hdr_sector,
  output logic       hdr_err,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_di,
  output logic       ram_we,
  output logic       sec_done,
  output logic       sec_err
);

  typedef enum logic [1:0] {S_IDLE, S_ID, S_HDR, S_DATA} state_t;

  // Returns {error, nibble}; illegal codes decode as F with the error bit set.
  function automatic logic [4:0] gcr_decode(input logic [4:0] q);
    case (q)
      5'b01010: return 5'h00;  5'b01011: return 5'h01;
      5'b10010: return 5'h02;  5'b10011: return 5'h03;
      5'b01110: return 5'h04;  5'b01111: return 5'h05;
      5'b10110: return 5'h06;  5'b10111: return 5'h07;
      5'b01001: return 5'h08;  5'b11001: return 5'h09;
      5'b11010: return 5'h0A;  5'b11011: return 5'h0B;
      5'b01101: return 5'h0C;  5'b11101: return 5'h0D;
      5'b11110: return 5'h0E;  5'b10101: return 5'h0F;
      default:  return 5'h1F;
    endcase
  endfunction

  state_t     r_state, w_next;
  logic [3:0] r_ones, r_bitcnt;
  logic [8:0] r_shift, r_cnt;
  logic       r_err, r_hdr_ok;
  logic [7:0] r_xor, r_hdr_cks, r_hdr_sec, r_hdr_trk, r_hdr_id2;
  logic [7:0] r_dout, r_ram_addr, r_ram_di;
  logic       r_byte_n, r_hdr_valid, r_hdr_err, r_ram_we, r_sec_done, r_sec_err;
  logic [5:0] r_hdr_track;
  logic [4:0] r_hdr_sector;

  logic       w_act, w_sync_hit, w_sync_end, w_byte_done;
  logic       w_gcr_err, w_hdr_bad, w_sec_bad;
  logic [9:0] w_word;
  logic [4:0] w_hi, w_lo;
  logic [7:0] w_byte;

  assign w_act       = mtr & bit_en;
  assign w_sync_hit  = w_act & bit_in & (r_ones >= 4'd9);
  assign w_sync_end  = w_act & ~bit_in & (r_ones == 4'd10);
  assign w_byte_done = w_act & ~w_sync_hit & ~w_sync_end & (r_bitcnt == 4'd9);
  assign w_word      = {r_shift, bit_in};
  assign w_hi        = gcr_decode(w_word[9:5]);
  assign w_lo        = gcr_decode(w_word[4:0]);
  assign w_byte      = {w_hi[3:0], w_lo[3:0]};
  assign w_gcr_err   = w_hi[4] | w_lo[4];
  assign w_hdr_bad   = r_err | w_gcr_err |
                       (r_hdr_cks != (r_hdr_sec ^ r_hdr_trk ^ r_hdr_id2 ^ w_byte));
  assign w_sec_bad   = r_err | w_gcr_err | (r_xor != w_byte);

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    if (!mtr || w_sync_hit) begin
      w_next = S_IDLE;
    end else if (w_sync_end) begin
      w_next = S_ID;
    end else if (w_byte_done) begin
      case (r_state)
        S_ID: begin
          if (w_byte == 8'h08)                  w_next = S_HDR;
          else if (w_byte == 8'h07 && r_hdr_ok) w_next = S_DATA;
          else                                  w_next = S_IDLE;
        end
        S_HDR:   if (r_cnt == 9'd4)   w_next = S_IDLE;
        S_DATA:  if (r_cnt == 9'd256) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      r_ones <= '0;        r_bitcnt <= '0;      r_shift <= '0;       r_cnt <= '0;
      r_err <= 1'b0;       r_hdr_ok <= 1'b0;    r_xor <= '0;
      r_hdr_cks <= '0;     r_hdr_sec <= '0;     r_hdr_trk <= '0;     r_hdr_id2 <= '0;
      r_dout <= '0;        r_byte_n <= 1'b1;    r_hdr_valid <= 1'b0;
      r_hdr_track <= '0;   r_hdr_sector <= '0;  r_hdr_err <= 1'b0;
      r_ram_addr <= '0;    r_ram_di <= '0;      r_ram_we <= 1'b0;
      r_sec_done <= 1'b0;  r_sec_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // pre-edge values regardless of statement order.
      r_byte_n    <= 1'b1;
      r_hdr_valid <= 1'b0;
      r_ram_we    <= 1'b0;
      r_sec_done  <= 1'b0;
      if (!mtr) begin
        r_ones   <= '0;
        r_bitcnt <= '0;
      end else if (bit_en) begin
        r_ones  <= !bit_in ? 4'd0 : (r_ones == 4'd10) ? 4'd10 : r_ones + 4'd1;
        r_shift <= w_word[8:0];
        if (w_sync_hit)                 r_bitcnt <= 4'd0;
        else if (w_sync_end)            r_bitcnt <= 4'd1;
        else if (r_bitcnt == 4'd9)      r_bitcnt <= 4'd0;
        else                            r_bitcnt <= r_bitcnt + 4'd1;
      end
      if (w_byte_done) begin
        r_dout   <= w_byte;
        r_byte_n <= 1'b0;
        case (r_state)
          S_ID: begin
            r_cnt <= '0;
            r_err <= 1'b0;
            r_xor <= '0;
            // A data block consumes the stored header, good or not.
            if (w_byte == 8'h07) r_hdr_ok <= 1'b0;
          end
          S_HDR: begin
            r_err <= r_err | w_gcr_err;
            r_cnt <= r_cnt + 9'd1;
            case (r_cnt[2:0])
              3'd0:    r_hdr_cks <= w_byte;
              3'd1:    r_hdr_sec <= w_byte;
              3'd2:    r_hdr_trk <= w_byte;
              3'd3:    r_hdr_id2 <= w_byte;
              default: begin
                r_hdr_valid  <= 1'b1;
                r_hdr_err    <= w_hdr_bad;
                r_hdr_track  <= r_hdr_trk[5:0];
                r_hdr_sector <= r_hdr_sec[4:0];
                r_hdr_ok     <= ~w_hdr_bad;
              end
            endcase
          end
          S_DATA: begin
            if (r_cnt[8]) begin
              r_sec_done <= 1'b1;
              r_sec_err  <= w_sec_bad;
              r_ram_addr <= '0;
            end else begin
              r_ram_we   <= 1'b1;
              r_ram_addr <= r_cnt[7:0];
              r_ram_di   <= w_byte;
              r_xor      <= r_xor ^ w_byte;
              r_err      <= r_err | w_gcr_err;
              r_cnt      <= r_cnt + 9'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sync_n     = (r_ones != 4'd10);
  assign dout       = r_dout;
  assign byte_n     = r_byte_n;
  assign hdr_valid  = r_hdr_valid;
  assign hdr_track  = r_hdr_track;
  assign hdr_sector = r_hdr_sector;
  assign hdr_err    = r_hdr_err;
  assign ram_addr   = r_ram_addr;
  assign ram_di     = r_ram_di;
  assign ram_we     = r_ram_we;
  assign sec_done   = r_sec_done;
  assign sec_err    = r_sec_err;

endmodule

// File: tb/tb_c1541_gcr_decoder.sv
// Scoreboard bench for c1541_gcr_decoder: GCR-encodes headers and sectors,
// queues the expected bytes, writes and pulses, and compares as they appear.
`timescale 1ns/1ps
module tb_c1541_gcr_decoder;

  logic       clk32 = 1'b0;
  logic       reset_n = 1'b0, mtr = 1'b0, bit_en = 1'b0, bit_in = 1'b0;
  logic       sync_n, byte_n, hdr_valid, hdr_err, ram_we, sec_done, sec_err;
  logic [7:0] dout, ram_addr, ram_di;
  logic [5:0] hdr_track;
  logic [4:0] hdr_sector;

  int checks = 0;
  int failures = 0;

  logic [7:0]  q_dout[$];
  logic [15:0] q_ram[$];
  logic [11:0] q_hdr[$];
  logic        q_sec[$];

  localparam logic [41:0] RESET_VEC = {1'b1, 1'b1, 8'h00, 1'b0, 6'h00, 5'h00,
                                       1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

  always #15.625 clk32 = ~clk32;

  c1541_gcr_decoder dut (
    .clk32(clk32), .reset_n(reset_n), .mtr(mtr), .bit_en(bit_en), .bit_in(bit_in),
    .sync_n(sync_n), .dout(dout), .byte_n(byte_n), .hdr_valid(hdr_valid),
    .hdr_track(hdr_track), .hdr_sector(hdr_sector), .hdr_err(hdr_err),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we),
    .sec_done(sec_done), .sec_err(sec_err)
  );

  function automatic logic [41:0] out_vec();
    return {sync_n, byte_n, dout, hdr_valid, hdr_track, hdr_sector, hdr_err,
            ram_addr, ram_di, ram_we, sec_done, sec_err};
  endfunction

  function automatic logic [4:0] gcr_enc(input logic [3:0] n);
    case (n)
      4'h0: return 5'b01010;  4'h1: return 5'b01011;
      4'h2: return 5'b10010;  4'h3: return 5'b10011;
      4'h4: return 5'b01110;  4'h5: return 5'b01111;
      4'h6: return 5'b10110;  4'h7: return 5'b10111;
      4'h8: return 5'b01001;  4'h9: return 5'b11001;
      4'hA: return 5'b11010;  4'hB: return 5'b11011;
      4'hC: return 5'b01101;  4'hD: return 5'b11101;
      4'hE: return 5'b11110;  default: return 5'b10101;
    endcase
  endfunction

  // Output monitor: every pulse must match the head of its queue.
  task automatic monitor();
    logic [7:0]  e8;
    logic [15:0] e16;
    logic [11:0] e12;
    logic        e1;
    forever begin
      @(negedge clk32);
      if (reset_n) begin
        if (!byte_n) begin
          checks++;
          if (q_dout.size() == 0) begin
            failures++; $display("FAIL byte_pulse unexpected dout=%h", dout);
          end else begin
            e8 = q_dout.pop_front();
            if (dout !== e8) begin failures++; $display("FAIL dout got=%h want=%h", dout, e8); end
          end
        end
        if (ram_we) begin
          checks++;
          if (q_ram.size() == 0) begin
            failures++; $display("FAIL ram_we unexpected addr=%h di=%h", ram_addr, ram_di);
          end else begin
            e16 = q_ram.pop_front();
            if ({ram_addr, ram_di} !== e16) begin
              failures++; $display("FAIL ram_write got=%h/%h want=%h/%h", ram_addr, ram_di, e16[15:8], e16[7:0]);
            end
          end
        end
        if (hdr_valid) begin
          checks++;
          if (q_hdr.size() == 0) begin
            failures++; $display("FAIL hdr_valid unexpected");
          end else begin
            e12 = q_hdr.pop_front();
            if ({hdr_track, hdr_sector, hdr_err} !== e12) begin
              failures++; $display("FAIL header got trk=%0d sec=%0d err=%b want trk=%0d sec=%0d err=%b",
                                   hdr_track, hdr_sector, hdr_err, e12[11:6], e12[5:1], e12[0]);
            end
          end
        end
        if (sec_done) begin
          checks++;
          if (q_sec.size() == 0) begin
            failures++; $display("FAIL sec_done unexpected");
          end else begin
            e1 = q_sec.pop_front();
            if (sec_err !== e1) begin failures++; $display("FAIL sec_err got=%b want=%b", sec_err, e1); end
          end
        end
      end
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk32);
    bit_en = 1'b1;
    bit_in = b;
    @(negedge clk32);
    bit_en = 1'b0;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_word10(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    q_dout.push_back(b);
    send_word10({gcr_enc(b[7:4]), gcr_enc(b[3:0])});
  endtask

  task automatic send_header(input logic [7:0] sec, input logic [7:0] trk);
    logic [7:0] cks;
    cks = sec ^ trk ^ 8'h20 ^ 8'h20;
    q_hdr.push_back({trk[5:0], sec[4:0], 1'b0});
    send_ones(40);
    send_byte(8'h08); send_byte(cks); send_byte(sec); send_byte(trk);
    send_byte(8'h20); send_byte(8'h20);
  endtask

  task automatic send_data_block(input logic [7:0] cks, input logic exp_err);
    logic [7:0] b;
    send_ones(40);
    send_byte(8'h07);
    for (int n = 0; n < 256; n++) begin
      b = 8'(n);
      q_ram.push_back({b, b});
      send_byte(b);
    end
    q_sec.push_back(exp_err);
    send_byte(cks);
  endtask

  task automatic drain_and_check(input string name);
    repeat (3) @(negedge clk32);
    checks++;
    if (q_dout.size() + q_ram.size() + q_hdr.size() + q_sec.size() != 0) begin
      failures++;
      $display("FAIL %s pending dout=%0d ram=%0d hdr=%0d sec=%0d (want all 0)", name,
               q_dout.size(), q_ram.size(), q_hdr.size(), q_sec.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk32);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++; $display("FAIL reset_outputs got=%h want=%h", out_vec(), RESET_VEC);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk32);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++; $display("FAIL post_release_outputs got=%h want=%h", out_vec(), RESET_VEC);
    end
    mtr = 1'b1;
  endtask

  task automatic test_header();
    send_ones(40);
    checks++;
    if (sync_n !== 1'b0) begin failures++; $display("FAIL sync_detect sync_n=%b want=0", sync_n); end
    q_hdr.push_back({6'd18, 5'd1, 1'b0});
    send_byte(8'h08); send_byte(8'h13); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h20); send_byte(8'h20);
    drain_and_check("header");
    checks++;
    if ({hdr_track, hdr_sector, hdr_err} !== {6'd18, 5'd1, 1'b0}) begin
      failures++; $display("FAIL header_hold trk=%0d sec=%0d err=%b want 18/1/0", hdr_track, hdr_sector, hdr_err);
    end
  endtask

  task automatic test_data();
    send_data_block(8'h00, 1'b0);
    drain_and_check("data");
    checks++;
    if (ram_addr !== 8'h00) begin failures++; $display("FAIL addr_wrap ram_addr=%h want=00", ram_addr); end
  endtask

  task automatic test_checksum_fault();
    send_header(8'h05, 8'h11);
    send_data_block(8'h01, 1'b1);
    drain_and_check("checksum_fault");
  endtask

  task automatic test_illegal_quintet();
    q_hdr.push_back({6'd18, 5'h11, 1'b1});
    send_ones(40);
    send_byte(8'h08); send_byte(8'h13);
    q_dout.push_back(8'hF1);
    send_word10({5'b00000, gcr_enc(4'h1)});
    send_byte(8'h12); send_byte(8'h20); send_byte(8'h20);
    send_ones(40);
    send_byte(8'h07);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'h55);
    drain_and_check("illegal_quintet");
  endtask

  task automatic test_abort();
    logic [7:0] b;
    send_header(8'h02, 8'h12);
    send_ones(40);
    send_byte(8'h07);
    for (int n = 0; n <= 100; n++) begin
      b = 8'(n);
      q_ram.push_back({b, b});
      send_byte(b);
    end
    send_ones(12);
    repeat (2) @(negedge clk32);
    checks++;
    if (sync_n !== 1'b0) begin failures++; $display("FAIL abort_sync sync_n=%b want=0", sync_n); end
    drain_and_check("abort");
    checks++;
    if (ram_addr !== 8'd100) begin failures++; $display("FAIL abort_addr ram_addr=%0d want=100", ram_addr); end
  endtask

  task automatic test_async_reset();
    logic [7:0] b;
    send_header(8'h03, 8'h12);
    send_ones(40);
    send_byte(8'h07);
    for (int n = 0; n < 50; n++) begin
      b = 8'(n);
      q_ram.push_back({b, b});
      send_byte(b);
    end
    @(posedge clk32);
    #5 reset_n = 1'b0;
    #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++; $display("FAIL async_reset got=%h want=%h", out_vec(), RESET_VEC);
    end
    repeat (2) @(negedge clk32);
    reset_n = 1'b1;
    drain_and_check("reset_mid_data");
    send_ones(40);
    send_byte(8'h08); send_byte(8'h13); send_byte(8'h01);
    @(negedge clk32);
    mtr = 1'b0;
    send_word10({gcr_enc(4'h1), gcr_enc(4'h2)});
    send_word10({gcr_enc(4'h2), gcr_enc(4'h0)});
    send_word10({gcr_enc(4'h2), gcr_enc(4'h0)});
    checks++;
    if ({sync_n, byte_n, hdr_valid, ram_we, sec_done} !== 5'b11000) begin
      failures++; $display("FAIL mtr_off_idle got=%b want=11000", {sync_n, byte_n, hdr_valid, ram_we, sec_done});
    end
    mtr = 1'b1;
    send_ones(15);
    checks++;
    if (sync_n !== 1'b0) begin failures++; $display("FAIL resync sync_n=%b want=0", sync_n); end
    @(negedge clk32);
    mtr = 1'b0;
    @(negedge clk32);
    checks++;
    if (sync_n !== 1'b1) begin failures++; $display("FAIL mtr_clear_sync sync_n=%b want=1", sync_n); end
    mtr = 1'b1;
    drain_and_check("mtr_mid_header");
    send_header(8'h07, 8'h23);
    send_data_block(8'h00, 1'b0);
    drain_and_check("clean_after_reset");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_header();
    test_data();
    test_checksum_fault();
    test_illegal_quintet();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
